// File: rtl/sd_pkg.sv
// Shared definitions for the sigma-delta DAC interpolator: FSM state type
// and the offset-binary midscale helper.
package sd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } sd_state_e;

  // Midscale of an offset-binary word of the given width, i.e. 1 << (width-1).
  function automatic logic [31:0] midscale(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/sd_sample_fifo.sv
// Small sample FIFO feeding the interpolator; the head word is visible on
// pop_data without a read cycle so a pop can load a segment the same clock.
module sd_sample_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic              do_push;
  logic              do_pop;

  // Status comes from the registered count only, so a same-cycle push never
  // makes an empty FIFO poppable.
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    always_comb begin
      mem_d[gi] = mem_q[gi];
      if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
        mem_d[gi] = push_data;
      end
    end

    always_ff @(posedge clk) begin
      mem_q[gi] <= mem_d[gi];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dac_interpolator.sv
// Linear-ramp interpolator: each FIFO sample ends a 2^OSR_LOG2-clock ramp
// from the previous sample, emitted as offset binary to a sigma-delta DAC.
module dac_interpolator
  import sd_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int OSR_LOG2   = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] dac_out,
  output logic              underrun,
  output logic              running
);

  localparam int                ACC_W = DATA_W + OSR_LOG2;
  localparam logic [DATA_W-1:0] MID   = DATA_W'(midscale(DATA_W));

  sd_state_e             state_q, state_d;
  logic [DATA_W-1:0]     prev_q, prev_d;
  logic [DATA_W-1:0]     cur_q, cur_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [OSR_LOG2-1:0]   phase_q, phase_d;
  logic [DATA_W-1:0]     dac_out_q, dac_out_d;
  logic                  underrun_q, underrun_d;

  logic signed [DATA_W:0]  delta;
  logic [ACC_W-1:0]        delta_ext;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_pop;
  logic [DATA_W-1:0]       fifo_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;

  assign s_ready  = !fifo_full && !rst;
  assign running  = (state_q == ST_RUN);
  assign dac_out  = dac_out_q;
  assign underrun = underrun_q;

  assign delta     = $signed({1'b0, cur_q}) - $signed({1'b0, prev_q});
  assign delta_ext = ACC_W'(delta);

  sd_sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s_valid && s_ready),
    .push_data (s_data ^ MID),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_unused)
  );

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    cur_d      = cur_q;
    acc_d      = acc_q;
    phase_d    = phase_q;
    underrun_d = 1'b0;
    fifo_pop   = 1'b0;
    dac_out_d  = acc_q[ACC_W-1:OSR_LOG2];

    // A segment ends on the last phase; IDLE and HOLD start one whenever data waits.
    if ((state_q != ST_RUN) || (phase_q == '1)) begin
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        prev_d   = cur_q;
        cur_d    = fifo_data;
        acc_d    = {cur_q, {OSR_LOG2{1'b0}}};
        phase_d  = '0;
        state_d  = ST_RUN;
      end else if (state_q == ST_RUN) begin
        underrun_d = 1'b1;
        prev_d     = cur_q;
        acc_d      = {cur_q, {OSR_LOG2{1'b0}}};
        phase_d    = '0;
        state_d    = ST_HOLD;
      end
    end else begin
      acc_d   = acc_q + delta_ext;
      phase_d = phase_q + OSR_LOG2'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      prev_q     <= MID;
      cur_q      <= MID;
      acc_q      <= {MID, {OSR_LOG2{1'b0}}};
      phase_q    <= '0;
      dac_out_q  <= MID;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      cur_q      <= cur_d;
      acc_q      <= acc_d;
      phase_q    <= phase_d;
      dac_out_q  <= dac_out_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_dac_interpolator.sv
// Bench for dac_interpolator (DATA_W=16, OSR_LOG2=2, FIFO_DEPTH=4): directed
// vector table, hand sequences, then random traffic against a ramp model.
module tb_dac_interpolator;

  localparam int DW    = 16;
  localparam int OSR   = 2;
  localparam int DEPTH = 4;
  localparam int N     = 1 << OSR;
  localparam int MID   = 32768;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] dac_out;
  logic          underrun;
  logic          running;

  int vectors     = 0;
  int miscompares = 0;

  dac_interpolator #(
    .DATA_W     (DW),
    .OSR_LOG2   (OSR),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .dac_out  (dac_out),
    .underrun (underrun),
    .running  (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          v;
    logic [15:0] d;
    logic [15:0] dac;
    bit          und;
    bit          run;
    bit          rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit v, logic [15:0] d, logic [15:0] dac,
                              bit und, bit run, bit rdy);
    vec_t t;
    t.rst = r; t.v = v; t.d = d; t.dac = dac; t.und = und; t.run = run; t.rdy = rdy;
    return t;
  endfunction

  // Reference model: FIFO as a queue, output as a linear interpolation
  // prev + k*(cur-prev)/N for the k-th clock of each segment.
  int q[$];
  int m_mode, m_prev, m_cur, m_k;
  int e_dac, e_und, e_run, e_rdy;

  task automatic model_load();
    m_prev = m_cur;
    m_cur  = q.pop_front();
    m_k    = 0;
    m_mode = M_RUN;
  endtask

  task automatic model_edge(input bit r, input bit v, input logic [15:0] d);
    bit can_push;
    bit have;
    if (r) begin
      q.delete();
      m_mode = M_IDLE; m_prev = MID; m_cur = MID; m_k = 0;
      e_dac = MID; e_und = 0; e_run = 0; e_rdy = 0;
      return;
    end
    can_push = (q.size() < DEPTH);
    have     = (q.size() > 0);
    e_und    = 0;
    case (m_mode)
      M_IDLE: begin
        e_dac = MID;
        if (have) model_load();
      end
      M_HOLD: begin
        e_dac = m_cur;
        if (have) model_load();
      end
      default: begin
        e_dac = (m_prev * N + m_k * (m_cur - m_prev)) / N;
        if (m_k == N - 1) begin
          if (have) model_load();
          else begin
            e_und  = 1;
            m_prev = m_cur;
            m_mode = M_HOLD;
          end
        end else begin
          m_k++;
        end
      end
    endcase
    if (v && can_push) q.push_back(int'($signed(d)) + MID);
    e_run = (m_mode == M_RUN);
    e_rdy = (q.size() < DEPTH);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive_edge(input bit r, input bit v, input logic [15:0] d);
    rst     = r;
    s_valid = v;
    s_data  = d;
    @(posedge clk);
    model_edge(r, v, d);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".dac_out"},  32'(dac_out),  32'(e_dac));
    chk({tag, ".underrun"}, 32'(underrun), 32'(e_und));
    chk({tag, ".running"},  32'(running),  32'(e_run));
    chk({tag, ".s_ready"},  32'(s_ready),  32'(e_rdy));
  endtask

  logic [15:0] fill_vals [6];
  int          density;
  logic [15:0] rd;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0;

    // Reset, single sample -> underrun/HOLD, HOLD -> full-scale ramp
    tbl.push_back(mk(1,0,16'h0000, 16'h8000,0,0,0));
    tbl.push_back(mk(0,1,16'h4000, 16'h8000,0,0,1));
    tbl.push_back(mk(0,0,16'h0000, 16'h8000,0,1,1));
    tbl.push_back(mk(0,0,16'h0000, 16'h8000,0,1,1));
    tbl.push_back(mk(0,0,16'h0000, 16'h9000,0,1,1));
    tbl.push_back(mk(0,0,16'h0000, 16'hA000,0,1,1));
    tbl.push_back(mk(0,0,16'h0000, 16'hB000,1,0,1));
    tbl.push_back(mk(0,0,16'h0000, 16'hC000,0,0,1));
    tbl.push_back(mk(0,0,16'h0000, 16'hC000,0,0,1));
    tbl.push_back(mk(0,1,16'h7FFF, 16'hC000,0,0,1));
    tbl.push_back(mk(0,0,16'h0000, 16'hC000,0,1,1));
    tbl.push_back(mk(0,0,16'h0000, 16'hC000,0,1,1));
    tbl.push_back(mk(0,0,16'h0000, 16'hCFFF,0,1,1));
    tbl.push_back(mk(0,0,16'h0000, 16'hDFFF,0,1,1));
    tbl.push_back(mk(0,0,16'h0000, 16'hEFFF,1,0,1));
    tbl.push_back(mk(0,0,16'h0000, 16'hFFFF,0,0,1));
    // Most negative input ramps down to zero without wrapping
    tbl.push_back(mk(1,0,16'h0000, 16'h8000,0,0,0));
    tbl.push_back(mk(0,1,16'h8000, 16'h8000,0,0,1));
    tbl.push_back(mk(0,0,16'h0000, 16'h8000,0,1,1));
    tbl.push_back(mk(0,0,16'h0000, 16'h8000,0,1,1));
    tbl.push_back(mk(0,0,16'h0000, 16'h6000,0,1,1));
    tbl.push_back(mk(0,0,16'h0000, 16'h4000,0,1,1));
    tbl.push_back(mk(0,0,16'h0000, 16'h2000,1,0,1));
    tbl.push_back(mk(0,0,16'h0000, 16'h0000,0,0,1));
    // Back-to-back segments stay gapless with running held high
    tbl.push_back(mk(1,0,16'h0000, 16'h8000,0,0,0));
    tbl.push_back(mk(0,1,16'h4000, 16'h8000,0,0,1));
    tbl.push_back(mk(0,1,16'hC000, 16'h8000,0,1,1));
    tbl.push_back(mk(0,0,16'h0000, 16'h8000,0,1,1));
    tbl.push_back(mk(0,0,16'h0000, 16'h9000,0,1,1));
    tbl.push_back(mk(0,0,16'h0000, 16'hA000,0,1,1));
    tbl.push_back(mk(0,0,16'h0000, 16'hB000,0,1,1));
    tbl.push_back(mk(0,0,16'h0000, 16'hC000,0,1,1));
    tbl.push_back(mk(0,0,16'h0000, 16'hA000,0,1,1));
    tbl.push_back(mk(0,0,16'h0000, 16'h8000,0,1,1));
    tbl.push_back(mk(0,0,16'h0000, 16'h6000,1,0,1));
    tbl.push_back(mk(0,0,16'h0000, 16'h4000,0,0,1));

    foreach (tbl[i]) begin
      drive_edge(tbl[i].rst, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d.dac_out", i),  32'(dac_out),  32'(tbl[i].dac));
      chk($sformatf("tbl%0d.underrun", i), 32'(underrun), 32'(tbl[i].und));
      chk($sformatf("tbl%0d.running", i),  32'(running),  32'(tbl[i].run));
      chk($sformatf("tbl%0d.s_ready", i),  32'(s_ready),  32'(tbl[i].rdy));
    end

    // FIFO fills while the first segment runs; sixth sample waits for a pop
    fill_vals[0] = 16'h1000; fill_vals[1] = 16'h2000; fill_vals[2] = 16'h3000;
    fill_vals[3] = 16'h4000; fill_vals[4] = 16'h5000; fill_vals[5] = 16'h6000;
    drive_edge(1, 0, '0);
    cmp_model("fill.rst");
    for (int j = 0; j < 5; j++) begin
      drive_edge(0, 1, fill_vals[j]);
      cmp_model($sformatf("fill.push%0d", j));
    end
    chk("fill.ready_low_when_full", 32'(s_ready), 32'd0);
    drive_edge(0, 1, fill_vals[5]);
    chk("fill.ready_after_pop", 32'(s_ready), 32'd1);
    drive_edge(0, 1, fill_vals[5]);
    cmp_model("fill.push5");
    for (int j = 0; j < 30; j++) begin
      drive_edge(0, 0, '0);
      cmp_model($sformatf("fill.drain%0d", j));
    end
    chk("fill.hold_last", 32'(dac_out), 32'(fill_vals[5] ^ 16'h8000));

    // Reset mid-ramp with three samples queued
    drive_edge(1, 0, '0);
    for (int j = 0; j < 4; j++) begin
      drive_edge(0, 1, 16'h2000 + 16'(j * 16'h1000));
      cmp_model($sformatf("abort.push%0d", j));
    end
    drive_edge(1, 0, '0);
    chk("abort.dac_out",  32'(dac_out),  32'h8000);
    chk("abort.running",  32'(running),  32'd0);
    chk("abort.underrun", 32'(underrun), 32'd0);
    for (int j = 0; j < 6; j++) begin
      drive_edge(0, 0, '0);
      chk($sformatf("abort.idle%0d.dac_out", j),  32'(dac_out),  32'h8000);
      chk($sformatf("abort.idle%0d.running", j),  32'(running),  32'd0);
      chk($sformatf("abort.idle%0d.underrun", j), 32'(underrun), 32'd0);
      chk($sformatf("abort.idle%0d.s_ready", j),  32'(s_ready),  32'd1);
    end

    // Random traffic with varying density, extreme codes and rare resets
    density = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) density = $urandom_range(0, 100);
      case ($urandom_range(0, 7))
        0:       rd = 16'h8000;
        1:       rd = 16'h7FFF;
        default: rd = 16'($urandom);
      endcase
      drive_edge($urandom_range(0, 399) == 0, $urandom_range(0, 99) < density, rd);
      cmp_model($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
